// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// slave  : arbiter side (takes requests, drives grants)
// master : requester side (drives requests, observes grants)
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters.
// A grant is registered one-hot, held until the owner releases it (done or
// dropping its request), then priority moves to the requester after the owner.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces a release after
// MAX_HOLD grant cycles and pulses timeout; without it grants are held forever.
module rr_arbiter8 #(
    parameter logic [2:0] PTR_INIT = 3'd0
`ifdef ARB_TIMEOUT_EN
    , parameter int MAX_HOLD = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter8_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [2:0] ptr_q, ptr_d;

    logic       found;
    logic [2:0] sel;
    logic       rel_normal;
    logic       expire;

    // Owner gives up the resource: explicit done or its request went away.
    assign rel_normal = bus.done | ~bus.req[idx_q];

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!found && bus.req[ptr_q + 3'(i)]) begin
                found = 1'b1;
                sel   = ptr_q + 3'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;

    assign expire = (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter runs only while owned; timeout flags a forced (not voluntary) release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_q == GRANT) && expire && !rel_normal;
            if (state_q == GRANT && !rel_normal && !expire)
                hold_q <= hold_q + 8'd1;
            else
                hold_q <= 8'd0;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // State, grant and priority pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr_q   <= PTR_INIT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: grant from IDLE, release from GRANT. A release always lands in
    // IDLE, so there is at least one all-zero cycle between owners.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = 8'h01 << sel;
                    idx_d   = sel;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (rel_normal || expire) begin
                    state_d = IDLE;
                    grant_d = 8'h00;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
endmodule
